// File: rtl/multiword_add_pkg.sv
// rtl/multiword_add_pkg.sv - shared types, defaults and flag helper for multiword_add_seq
package multiword_add_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_NWORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic ovf_rule(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational WORD_W-bit adder slice with carry in/out
module add_slice #(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};

endmodule

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - word-serial multiword adder; MULTIWORD_ADD_SEQ_SUB_EN adds a subtract port
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int NWORDS = DEF_NWORDS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    input  logic                     sub,
`endif
    input  logic [WORD_W*NWORDS-1:0] a_in,
    input  logic [WORD_W*NWORDS-1:0] b_in,
    output logic [WORD_W*NWORDS-1:0] result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     carry,
    output logic                     sign,
    output logic                     zero,
    output logic                     parity,
    output logic                     overflow,
    output logic                     busy
);

    localparam int TOT_W = WORD_W * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TOT_W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic                sub_q, sub_d;
    logic                cy_q, cy_d, zacc_q, zacc_d, pacc_q, pacc_d;
    logic                carry_q, carry_d, sign_q, sign_d, zero_q, zero_d;
    logic                parity_q, parity_d, ovf_q, ovf_d;

    logic [WORD_W-1:0]   a_word, b_word, sum_word;
    logic                slice_cout;

    // B is inverted on the way into the slice so subtraction reuses the same adder
    assign a_word = a_q[idx_q*WORD_W +: WORD_W];
    assign b_word = b_q[idx_q*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};

    add_slice #(.WORD_W(WORD_W)) u_slice (
        .a_i    (a_word),
        .b_i    (b_word),
        .cin_i  (cy_q),
        .sum_o  (sum_word),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        result_d = result_q;
        cy_d     = cy_q;
        zacc_d   = zacc_q;
        pacc_d   = pacc_q;
        carry_d  = carry_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d      = a_in;
                    b_d      = b_in;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
                    sub_d    = sub;
                    cy_d     = sub;
`else
                    sub_d    = 1'b0;
                    cy_d     = 1'b0;
`endif
                    result_d = '0;
                    idx_d    = '0;
                    zacc_d   = 1'b1;
                    pacc_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*WORD_W +: WORD_W] = sum_word;
                cy_d   = slice_cout;
                zacc_d = zacc_q & ~(|sum_word);
                pacc_d = pacc_q ^ (^sum_word);
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NWORDS - 1)) begin
                    idx_d    = '0;
                    carry_d  = slice_cout;
                    sign_d   = sum_word[WORD_W-1];
                    zero_d   = zacc_q & ~(|sum_word);
                    parity_d = ~(pacc_q ^ (^sum_word));
                    ovf_d    = ovf_rule(a_word[WORD_W-1], b_word[WORD_W-1], sum_word[WORD_W-1]);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            cy_q     <= 1'b0;
            zacc_q   <= 1'b0;
            pacc_q   <= 1'b0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            cy_q     <= cy_d;
            zacc_q   <= zacc_d;
            pacc_q   <= pacc_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            ovf_q    <= ovf_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign res_valid   = (state_q == DONE);
    assign result      = result_q;
    assign carry       = carry_q;
    assign sign        = sign_q;
    assign zero        = zero_q;
    assign parity      = parity_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - scoreboard bench for multiword_add_seq against an arithmetic model
module tb_multiword_add_seq;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TW = W * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid, start_ready, res_valid, res_ready;
    logic [TW-1:0] a_in, b_in, result;
    logic          carry, sign, zero, parity, overflow, busy;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    logic          sub;
`endif

    typedef struct packed {
        logic [TW-1:0] r;
        logic c, s, z, p, o;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hold_low = 0;
    bit   seen     = 0;
    bit   after_hs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiword_add_seq #(.WORD_W(W), .NWORDS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        .sub         (sub),
`endif
        .a_in        (a_in),
        .b_in        (b_in),
        .result      (result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .carry       (carry),
        .sign        (sign),
        .zero        (zero),
        .parity      (parity),
        .overflow    (overflow),
        .busy        (busy)
    );

    function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sb);
        exp_t          m;
        logic [TW:0]   full;
        logic [TW-1:0] be;
        be   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + (TW+1)'(sb);
        m.r  = full[TW-1:0];
        m.c  = full[TW];
        m.s  = m.r[TW-1];
        m.z  = (m.r == '0);
        m.p  = ~(^m.r);
        m.o  = (a[TW-1] == be[TW-1]) && (m.r[TW-1] != a[TW-1]);
        return m;
    endfunction

    task automatic chk_w(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sb, input bit push);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            if (start_ready) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) begin
            chk_b("start_ready_timeout", 1'b0, 1'b1);
            return;
        end
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        sub         = sb;
`endif
        @(posedge clk);
        #1;
        if (push) begin
            exp_q.push_back(model(a, b, sb));
            acc_q.push_back(cyc);
        end
        start_valid = 1'b0;
        a_in        = {2{$urandom()}};
        b_in        = {2{$urandom()}};
    endtask

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid && hold_low > 0) begin
                res_ready = 1'b0;
                hold_low--;
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (after_hs) begin
                chk_b("idle_after_handshake", start_ready, 1'b1);
                after_hs = 0;
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk_b("unexpected_res_valid", res_valid, 1'b0);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        chk_i("latency", cyc - acc_q[0], N);
                    end
                    chk_w("result", result, exp_q[0].r);
                    chk_b("carry", carry, exp_q[0].c);
                    chk_b("sign", sign, exp_q[0].s);
                    chk_b("zero", zero, exp_q[0].z);
                    chk_b("parity", parity, exp_q[0].p);
                    chk_b("overflow", overflow, exp_q[0].o);
                    chk_b("start_ready_in_done", start_ready, 1'b0);
                    chk_b("busy_in_done", busy, 1'b0);
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        seen     = 0;
                        after_hs = 1;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        reset       = 1'b1;
        start_valid = 1'b0;
        a_in        = '0;
        b_in        = '0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        sub         = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_b("rst_start_ready", start_ready, 1'b1);
        chk_b("rst_res_valid", res_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_w("rst_result", result, '0);
        chk_b("rst_flags", carry | sign | zero | parity | overflow, 1'b0);
        reset = 1'b0;

        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1);
        send(64'hBFFF_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1);
        send(64'h0, 64'h0, 1'b0, 1);

        hold_low = 5;
        send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1);

        // abort an operation while the third word is in the slice
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_b("busy_before_abort", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk_b("abort_res_valid", res_valid, 1'b0);
        chk_w("abort_result", result, '0);
        chk_b("abort_start_ready", start_ready, 1'b1);
        chk_b("abort_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_b("abort_idle_res_valid", res_valid, 1'b0);
        chk_b("abort_idle_start_ready", start_ready, 1'b1);

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        send(64'h0, 64'h1, 1'b1, 1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [TW-1:0] ra, rb;
            logic          rs;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (i % 5 == 0) rb = ~ra;
            if (i % 7 == 0) ra[TW-1 -: W] = {1'b0, {(W-1){1'b1}}};
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            send(ra, rb, rs, 1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk_i("drain_outstanding", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
